// File: rtl/multicycle_sequencer.sv
// Control sequencer for a multicycle RISC-V style core: FETCH/DECODE/EXECUTE/MEM/WB/TRAP,
// with memory wait timeouts and a wrapping retired-instruction counter.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R,
  input  logic             I,
  input  logic             I_load,
  input  logic             I_jalr,
  input  logic             S,
  input  logic             SB,
  input  logic             U_auipc,
  input  logic             U_lui,
  input  logic             UJ_jal,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write_en,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [8:0] cls;
  logic       one_hot;
  logic [8:0] wait_inc;
  logic       timeout;
  logic       retire;

  logic       imem_req_c, ir_write_c, dmem_req_c, dmem_we_c;
  logic       reg_write_en_c, pc_write_c, trap_c;
  logic [1:0] pc_src_c;

  assign cls      = {UJ_jal, U_lui, U_auipc, SB, S, I_jalr, I_load, I, R};
  assign one_hot  = (cls != 9'd0) && ((cls & (cls - 9'd1)) == 9'd0);
  // Timeout fires on the wait cycle that would bring the count up to MEM_TIMEOUT.
  assign wait_inc = {1'b0, wait_q} + 9'd1;
  assign timeout  = (wait_inc >= 9'(MEM_TIMEOUT));

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    instret_d      = instret_q;
    retire         = 1'b0;
    imem_req_c     = 1'b0;
    ir_write_c     = 1'b0;
    dmem_req_c     = 1'b0;
    dmem_we_c      = 1'b0;
    reg_write_en_c = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 2'b00;
    trap_c         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      ST_DECODE: begin
        state_d = one_hot ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        if (I_load || S) begin
          state_d = ST_MEM;
          wait_d  = 8'd0;
        end else if (SB) begin
          pc_write_c = 1'b1;
          pc_src_c   = branch_taken ? 2'b01 : 2'b00;
          retire     = 1'b1;
          state_d    = ST_FETCH;
          wait_d     = 8'd0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = S;
        if (dmem_ready) begin
          if (S) begin
            pc_write_c = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
            wait_d     = 8'd0;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end
      ST_WB: begin
        reg_write_en_c = 1'b1;
        pc_write_c     = 1'b1;
        pc_src_c       = UJ_jal ? 2'b01 : (I_jalr ? 2'b10 : 2'b00);
        retire         = 1'b1;
        state_d        = ST_FETCH;
        wait_d         = 8'd0;
      end
      ST_TRAP: begin
        trap_c = 1'b1;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Reset masks every output but state combinationally, so in-flight requests drop at once.
  always_comb begin
    imem_req     = imem_req_c & ~reset;
    ir_write     = ir_write_c & ~reset;
    dmem_req     = dmem_req_c & ~reset;
    dmem_we      = dmem_we_c & ~reset;
    reg_write_en = reg_write_en_c & ~reset;
    pc_write     = pc_write_c & ~reset;
    pc_src       = reset ? 2'b00 : pc_src_c;
    trap         = trap_c & ~reset;
    instret      = reset ? '0 : instret_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction cycle traces built from the sequencing rules,
// replayed against the DUT cycle by cycle.
module tb_multicycle_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    cls_v;
  logic          R, I, I_load, I_jalr, S, SB, U_auipc, U_lui, UJ_jal;
  logic          branch_taken, imem_ready, dmem_ready;
  logic          imem_req, ir_write, dmem_req, dmem_we, reg_write_en, pc_write, trap;
  logic [1:0]    pc_src;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  assign {UJ_jal, U_lui, U_auipc, SB, S, I_jalr, I_load, I, R} = cls_v;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .R(R), .I(I), .I_load(I_load), .I_jalr(I_jalr), .S(S), .SB(SB),
    .U_auipc(U_auipc), .U_lui(U_lui), .UJ_jal(UJ_jal),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write_en(reg_write_en), .pc_write(pc_write), .pc_src(pc_src),
    .trap(trap), .state(state), .instret(instret)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       trap;
  } outs_t;

  typedef struct {
    logic [8:0] cls;
    logic       bt;
    logic       irdy;
    logic       drdy;
    outs_t      o;
    bit         retire;
  } step_t;

  step_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    retired = 0;

  function automatic outs_t o_mk(input logic [2:0] st);
    outs_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r.st       = state;
    r.imem_req = imem_req;
    r.ir_write = ir_write;
    r.dmem_req = dmem_req;
    r.dmem_we  = dmem_we & dmem_req;
    r.reg_we   = reg_write_en;
    r.pc_write = pc_write;
    r.pc_src   = pc_src;
    r.trap     = trap;
    return r;
  endfunction

  task automatic add_step(input logic [8:0] c, input logic irdy, input logic drdy,
                          input outs_t o, input bit ret);
    step_t s;
    s.cls = c; s.bt = 1'b0; s.irdy = irdy; s.drdy = drdy; s.o = o; s.retire = ret;
    exp_q.push_back(s);
  endtask

  // One full instruction of class k (bit index into cls_v) with the given memory delays.
  task automatic add_instr(input int k, input logic bt, input int di, input int dd);
    step_t s;
    s.cls = 9'd1 << k;
    s.bt  = bt;
    for (int i = 0; i <= di; i++) begin
      s.irdy = (i == di); s.drdy = 1'b0; s.retire = 1'b0;
      s.o = o_mk(3'd0); s.o.imem_req = 1'b1; s.o.ir_write = (i == di);
      exp_q.push_back(s);
    end
    s.irdy = 1'b0; s.drdy = 1'b0; s.retire = 1'b0;
    s.o = o_mk(3'd1);
    exp_q.push_back(s);
    s.o = o_mk(3'd2);
    if (k == 5) begin
      s.o.pc_write = 1'b1; s.o.pc_src = bt ? 2'b01 : 2'b00; s.retire = 1'b1;
    end
    exp_q.push_back(s);
    s.retire = 1'b0;
    if (k == 2 || k == 4) begin
      for (int i = 0; i <= dd; i++) begin
        s.drdy = (i == dd); s.retire = 1'b0;
        s.o = o_mk(3'd3); s.o.dmem_req = 1'b1; s.o.dmem_we = (k == 4);
        if (k == 4 && i == dd) begin
          s.o.pc_write = 1'b1; s.retire = 1'b1;
        end
        exp_q.push_back(s);
      end
      s.drdy = 1'b0; s.retire = 1'b0;
    end
    if (k != 5 && k != 4) begin
      s.o = o_mk(3'd4); s.o.reg_we = 1'b1; s.o.pc_write = 1'b1; s.retire = 1'b1;
      s.o.pc_src = (k == 8) ? 2'b01 : ((k == 3) ? 2'b10 : 2'b00);
      exp_q.push_back(s);
    end
  endtask

  task automatic run_trace(input string tag);
    step_t s;
    outs_t act;
    int    n = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      cls_v = s.cls; branch_taken = s.bt; imem_ready = s.irdy; dmem_ready = s.drdy;
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== s.o) begin
        errors++;
        $display("FAIL %s step %0d outputs got %h want %h", tag, n, act, s.o);
      end
      checks++;
      if (instret !== CW'(retired)) begin
        errors++;
        $display("FAIL %s step %0d instret got %0d want %0d", tag, n, instret, CW'(retired));
      end
      if (s.retire) retired++;
      n++;
      @(posedge clk); #1;
    end
    cls_v = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset(input bit chk_pre, input logic [2:0] pre_st, input string tag);
    outs_t act;
    reset = 1'b1; cls_v = 9'h1FF; branch_taken = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    act = sample();
    if (chk_pre) begin
      checks++;
      if (act.st !== pre_st) begin
        errors++;
        $display("FAIL %s state before reset edge got %0d want %0d", tag, act.st, pre_st);
      end
    end
    act.st = 3'd0;
    checks++;
    if (act !== outs_t'(0) || instret !== '0) begin
      errors++;
      $display("FAIL %s outputs under reset got %h/%0d want 0/0", tag, act, instret);
    end
    @(posedge clk); #1;
    @(negedge clk);
    act = sample();
    checks++;
    if (act !== o_mk(3'd0) || instret !== '0) begin
      errors++;
      $display("FAIL %s after reset edge got %h/%0d want %h/0", tag, act, instret, o_mk(3'd0));
    end
    @(posedge clk); #1;
    reset = 1'b0; cls_v = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    retired = 0;
  endtask

  task automatic check_instret(input logic [CW-1:0] want, input string tag);
    @(negedge clk);
    checks++;
    if (instret !== want) begin
      errors++;
      $display("FAIL %s instret got %0d want %0d", tag, instret, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic add_trap_steps(input int n, input logic [8:0] c);
    outs_t o;
    o = o_mk(3'd5); o.trap = 1'b1;
    for (int i = 0; i < n; i++) add_step(c, 1'b1, 1'b1, o, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(1'b0, 3'd0, "reset");
  endtask

  task automatic test_r_type();
    add_instr(0, 1'b0, 0, 0);
    run_trace("r_type");
    check_instret(4'd1, "r_type_final");
  endtask

  task automatic test_load();
    do_reset(1'b0, 3'd0, "load_reset");
    add_instr(2, 1'b0, 0, 3);
    add_instr(4, 1'b0, 1, 2);
    run_trace("load_store");
  endtask

  task automatic test_branch();
    do_reset(1'b0, 3'd0, "branch_reset");
    add_instr(5, 1'b1, 0, 0);
    add_instr(5, 1'b0, 0, 0);
    run_trace("branch");
    check_instret(4'd2, "branch_final");
  endtask

  task automatic test_onehot_trap();
    outs_t o;
    do_reset(1'b0, 3'd0, "onehot_reset");
    o = o_mk(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1;
    add_step(9'h011, 1'b1, 1'b0, o, 1'b0);
    add_step(9'h011, 1'b0, 1'b0, o_mk(3'd1), 1'b0);
    add_trap_steps(10, 9'h011);
    run_trace("two_flags");
    do_reset(1'b1, 3'd5, "two_flags_reset");
    o = o_mk(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1;
    add_step(9'h000, 1'b1, 1'b0, o, 1'b0);
    add_step(9'h000, 1'b0, 1'b0, o_mk(3'd1), 1'b0);
    add_trap_steps(3, 9'h000);
    run_trace("zero_flags");
    do_reset(1'b1, 3'd5, "zero_flags_reset");
  endtask

  task automatic test_timeout();
    outs_t o;
    o = o_mk(3'd0); o.imem_req = 1'b1;
    for (int i = 0; i < TMO; i++) add_step(9'h001, 1'b0, 1'b0, o, 1'b0);
    add_trap_steps(3, 9'h001);
    run_trace("imem_timeout");
    do_reset(1'b1, 3'd5, "imem_timeout_reset");
    add_instr(0, 1'b0, TMO - 1, 0);
    add_instr(2, 1'b0, 0, TMO - 1);
    run_trace("ready_at_limit");
    o = o_mk(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1;
    add_step(9'h004, 1'b1, 1'b0, o, 1'b0);
    add_step(9'h004, 1'b0, 1'b0, o_mk(3'd1), 1'b0);
    add_step(9'h004, 1'b0, 1'b0, o_mk(3'd2), 1'b0);
    o = o_mk(3'd3); o.dmem_req = 1'b1;
    for (int i = 0; i < TMO; i++) add_step(9'h004, 1'b0, 1'b0, o, 1'b0);
    add_trap_steps(2, 9'h004);
    run_trace("dmem_timeout");
    do_reset(1'b1, 3'd5, "dmem_timeout_reset");
  endtask

  task automatic test_reset_mid_mem();
    outs_t o;
    o = o_mk(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1;
    add_step(9'h010, 1'b1, 1'b0, o, 1'b0);
    add_step(9'h010, 1'b0, 1'b0, o_mk(3'd1), 1'b0);
    add_step(9'h010, 1'b0, 1'b0, o_mk(3'd2), 1'b0);
    o = o_mk(3'd3); o.dmem_req = 1'b1; o.dmem_we = 1'b1;
    add_step(9'h010, 1'b0, 1'b0, o, 1'b0);
    run_trace("mid_mem");
    do_reset(1'b1, 3'd3, "mid_mem_reset");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) add_instr(8, 1'($urandom_range(0, 1)), 0, 0);
    run_trace("wrap");
    check_instret(4'd1, "wrap_final");
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0, 3'd0, "random_reset");
    for (int i = 0; i < 40; i++) begin
      add_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)));
    end
    run_trace("random");
  endtask

  initial begin
    cls_v = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; reset = 1'b1;
    test_reset();
    test_r_type();
    test_load();
    test_branch();
    test_onehot_trap();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
